// File: rtl/alu_pkg.sv
// Shared opcodes, sequencer states and status-register bit positions for the
// ALU sequencer and its flag generator.
package alu_pkg;

  localparam int W   = 16;
  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_MOV  = 5'h00;
  localparam logic [OPW-1:0] OP_ADD  = 5'h01;
  localparam logic [OPW-1:0] OP_ADDC = 5'h02;
  localparam logic [OPW-1:0] OP_SUB  = 5'h03;
  localparam logic [OPW-1:0] OP_SUBC = 5'h04;
  localparam logic [OPW-1:0] OP_CMP  = 5'h05;
  localparam logic [OPW-1:0] OP_DADD = 5'h06;
  localparam logic [OPW-1:0] OP_BIT  = 5'h07;
  localparam logic [OPW-1:0] OP_BIC  = 5'h08;
  localparam logic [OPW-1:0] OP_BIS  = 5'h09;
  localparam logic [OPW-1:0] OP_XOR  = 5'h0A;
  localparam logic [OPW-1:0] OP_AND  = 5'h0B;
  localparam logic [OPW-1:0] OP_CLR  = 5'h0C;
  localparam logic [OPW-1:0] OP_RRC  = 5'h10;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef enum logic [2:0] {ST_IDLE, ST_P1, ST_P2, ST_P3, ST_WB} state_t;

  // DADD runs as a plain binary ADD; anything unknown degrades to MOV.
  function automatic logic [OPW-1:0] norm_op(input logic [OPW-1:0] op);
    case (op)
      OP_DADD: return OP_ADD;
      OP_MOV, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_BIT, OP_BIC,
      OP_BIS, OP_XOR, OP_AND, OP_CLR, OP_RRC: return op;
      default: return OP_MOV;
    endcase
  endfunction

  function automatic logic [1:0] pass_count(input logic [OPW-1:0] op);
    case (op)
      OP_ADDC, OP_SUBC: return 2'd2;
      OP_BIS:           return 2'd3;
      default:          return 2'd1;
    endcase
  endfunction

  function automatic logic has_wb(input logic [OPW-1:0] op);
    return !(op == OP_CMP || op == OP_BIT);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Full-precision shadow of the operation on the original operands; produces
// {N,Z,C,V} and the locally computed rotate result independent of the ALU.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           cin,
  input  logic           byte_mode,
  output logic [W-1:0]   res,
  output logic [3:0]     flags,
  output logic           upd
);

  logic [W-1:0] mask;
  logic [W-1:0] opx;
  logic [W-1:0] opy;
  logic         c0;
  logic [W:0]   sum;
  logic         r_msb, x_msb, y_msb, a_msb, b_msb, carry, zero;

  always_comb begin
    mask  = byte_mode ? W'(8'hFF) : '1;
    opx   = a;
    opy   = b;
    c0    = 1'b0;
    flags = '0;
    upd   = 1'b0;
    // Subtracts are B + ~A + cin so carry reads as no-borrow.
    case (op)
      OP_ADDC:         c0 = cin;
      OP_SUB, OP_CMP:  begin opx = b; opy = ~a & mask; c0 = 1'b1; end
      OP_SUBC:         begin opx = b; opy = ~a & mask; c0 = cin;  end
      default: ;
    endcase
    sum = {1'b0, opx} + {1'b0, opy} + {{W{1'b0}}, c0};

    case (op)
      OP_AND, OP_BIT: res = a & b;
      OP_BIC:         res = ~a & b & mask;
      OP_XOR:         res = a ^ b;
      OP_RRC:         res = ((b & mask) >> 1) |
                            (byte_mode ? (W'(cin) << 7) : (W'(cin) << (W - 1)));
      default:        res = sum[W-1:0] & mask;
    endcase

    r_msb = byte_mode ? res[7] : res[W-1];
    x_msb = byte_mode ? opx[7] : opx[W-1];
    y_msb = byte_mode ? opy[7] : opy[W-1];
    a_msb = byte_mode ? a[7]   : a[W-1];
    b_msb = byte_mode ? b[7]   : b[W-1];
    carry = byte_mode ? sum[8] : sum[W];
    zero  = (res == '0);

    flags[SR_N] = r_msb;
    flags[SR_Z] = zero;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        flags[SR_C] = carry;
        flags[SR_V] = (x_msb == y_msb) && (r_msb != x_msb);
        upd         = 1'b1;
      end
      OP_AND, OP_BIT: begin
        flags[SR_C] = ~zero;
        upd         = 1'b1;
      end
      OP_XOR: begin
        flags[SR_C] = ~zero;
        flags[SR_V] = a_msb & b_msb;
        upd         = 1'b1;
      end
      OP_RRC: begin
        flags[SR_C] = b[0];
        upd         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller in front of the combinational ALU: one request at a
// time, composite ops split into ALU passes, owns the {N,Z,C,V} status register.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [OPW-1:0] req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  input  logic           req_byte,
  input  logic [3:0]     req_dst,
  output logic [OPW-1:0] alu_sel,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_result,
  output logic           wb_valid,
  input  logic           wb_ready,
  output logic [3:0]     wb_dst,
  output logic [W-1:0]   wb_data,
  input  logic           sr_we,
  input  logic [3:0]     sr_wdata,
  output logic [3:0]     sr,
  output logic           busy
);

  state_t         state_reg, state_next;
  logic [OPW-1:0] op_reg;
  logic [W-1:0]   a_reg, b_reg, t1_reg, t2_reg, wdata_reg;
  logic           byte_reg, cin_reg;
  logic [3:0]     dst_reg, sr_reg;
  logic           last_pass, accept, fg_upd;
  logic [1:0]     passes;
  logic [W-1:0]   in_mask, res_mask, res_final, fg_res;
  logic [3:0]     fg_flags;

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign busy      = (state_reg != ST_IDLE);
  assign wb_valid  = (state_reg == ST_WB);
  assign wb_data   = wdata_reg;
  assign wb_dst    = dst_reg;
  assign sr        = sr_reg;
  assign passes    = pass_count(op_reg);
  assign in_mask   = req_byte ? W'(8'hFF) : '1;
  assign res_mask  = byte_reg ? W'(8'hFF) : '1;
  // The rotate never touches the ALU; its value comes from the shadow.
  assign res_final = (op_reg == OP_RRC) ? fg_res : (alu_result & res_mask);

  alu_flag_gen u_flag_gen (
    .op        (op_reg),
    .a         (a_reg),
    .b         (b_reg),
    .cin       (cin_reg),
    .byte_mode (byte_reg),
    .res       (fg_res),
    .flags     (fg_flags),
    .upd       (fg_upd)
  );

  always_comb begin
    state_next = state_reg;
    alu_sel    = '0;
    alu_a      = '0;
    alu_b      = '0;
    last_pass  = 1'b0;
    case (state_reg)
      ST_IDLE: if (req_valid) state_next = ST_P1;
      ST_P1: begin
        last_pass = (passes == 2'd1);
        alu_sel   = op_reg;
        alu_a     = a_reg;
        alu_b     = b_reg;
        case (op_reg)
          OP_ADDC:         alu_sel = OP_ADD;
          OP_SUBC, OP_CMP: alu_sel = OP_SUB;
          OP_BIS:          alu_sel = OP_XOR;
          OP_BIT:          alu_sel = OP_AND;
          OP_BIC:          begin alu_sel = OP_AND; alu_a = ~a_reg; end
          default: ;
        endcase
        if (!last_pass)          state_next = ST_P2;
        else if (has_wb(op_reg)) state_next = ST_WB;
        else                     state_next = ST_IDLE;
      end
      ST_P2: begin
        last_pass = (passes == 2'd2);
        case (op_reg)
          OP_ADDC: begin
            alu_sel = OP_ADD;
            alu_a   = t1_reg;
            alu_b   = {{(W-1){1'b0}}, cin_reg};
          end
          OP_SUBC: begin
            alu_sel = OP_SUB;
            alu_a   = {{(W-1){1'b0}}, ~cin_reg};
            alu_b   = t1_reg;
          end
          default: begin
            alu_sel = OP_AND;
            alu_a   = a_reg;
            alu_b   = b_reg;
          end
        endcase
        state_next = last_pass ? ST_WB : ST_P3;
      end
      ST_P3: begin
        last_pass  = 1'b1;
        alu_sel    = OP_ADD;
        alu_a      = t1_reg;
        alu_b      = t2_reg;
        state_next = ST_WB;
      end
      ST_WB:   if (wb_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      t1_reg    <= '0;
      t2_reg    <= '0;
      wdata_reg <= '0;
      byte_reg  <= 1'b0;
      cin_reg   <= 1'b0;
      dst_reg   <= '0;
      sr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg   <= norm_op(req_op);
        a_reg    <= req_a & in_mask;
        b_reg    <= req_b & in_mask;
        byte_reg <= req_byte;
        dst_reg  <= req_dst;
        cin_reg  <= sr_reg[SR_C];
      end
      if (state_reg == ST_P1) t1_reg <= alu_result;
      if (state_reg == ST_P2) t2_reg <= alu_result;
      if (last_pass) wdata_reg <= res_final;
      // An external SR load overrides a same-cycle flag update.
      if (sr_we)                    sr_reg <= sr_wdata;
      else if (last_pass && fg_upd) sr_reg <= fg_flags;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model beside it.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [OPW-1:0] req_op = '0;
  logic [W-1:0]   req_a = '0;
  logic [W-1:0]   req_b = '0;
  logic           req_byte = 1'b0;
  logic [3:0]     req_dst = '0;
  logic [OPW-1:0] alu_sel;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic           wb_valid;
  logic           wb_ready = 1'b1;
  logic [3:0]     wb_dst;
  logic [W-1:0]   wb_data;
  logic           sr_we = 1'b0;
  logic [3:0]     sr_wdata = '0;
  logic [3:0]     sr;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_byte   (req_byte),
    .req_dst    (req_dst),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .sr_we      (sr_we),
    .sr_wdata   (sr_wdata),
    .sr         (sr),
    .busy       (busy)
  );

  // Behavioural ALU: subtract is dst - src (alu_b - alu_a).
  always_comb begin
    case (alu_sel)
      OP_MOV:  alu_result = alu_a;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_b - alu_a;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_CLR:  alu_result = 16'h0000;
      default: alu_result = 16'hDEAD;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Presents a request in the current cycle; returns one cycle after accept.
  task automatic send(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic byt, input logic [3:0] dst);
    req_op = op; req_a = a; req_b = b; req_byte = byt; req_dst = dst;
    req_valid = 1'b1;
    chk("req_ready_at_send", 16'(req_ready), 16'h1);
    step;
    req_valid = 1'b0;
  endtask

  task automatic load_sr(input logic [3:0] v);
    sr_we = 1'b1; sr_wdata = v;
    step;
    sr_we = 1'b0;
    chk("sr_load", 16'(sr), 16'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    repeat (3) step;
    chk("rst_sr", 16'(sr), 16'h0);
    chk("rst_wb_valid", 16'(wb_valid), 16'h0);
    rst = 1'b0;
    step;
    chk("idle_req_ready", 16'(req_ready), 16'h1);
    chk("idle_busy", 16'(busy), 16'h0);
    chk("idle_alu_sel", 16'(alu_sel), 16'h0);

    // ADD 7FFF + 0001
    send(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 4'd3);
    chk("add_p1_sel", 16'(alu_sel), 16'(OP_ADD));
    chk("add_p1_busy", 16'(busy), 16'h1);
    chk("add_p1_wbv", 16'(wb_valid), 16'h0);
    step;
    chk("add_wbv", 16'(wb_valid), 16'h1);
    chk("add_data", wb_data, 16'h8000);
    chk("add_dst", 16'(wb_dst), 16'h3);
    chk("add_sr", 16'(sr), 16'h9);
    chk("add_wb_alu_sel", 16'(alu_sel), 16'h0);
    step;
    chk("add_done_ready", 16'(req_ready), 16'h1);

    // ADDC with C=1
    load_sr(4'b0010);
    send(OP_ADDC, 16'hFFFF, 16'h0000, 1'b0, 4'd4);
    chk("addc_p1_sel", 16'(alu_sel), 16'(OP_ADD));
    chk("addc_p1_a", alu_a, 16'hFFFF);
    step;
    chk("addc_p2_sel", 16'(alu_sel), 16'(OP_ADD));
    chk("addc_p2_a", alu_a, 16'hFFFF);
    chk("addc_p2_b", alu_b, 16'h0001);
    chk("addc_p2_wbv", 16'(wb_valid), 16'h0);
    step;
    chk("addc_wbv", 16'(wb_valid), 16'h1);
    chk("addc_data", wb_data, 16'h0000);
    chk("addc_sr", 16'(sr), 16'h6);
    step;

    // BIS with write-back stalled for three cycles
    wb_ready = 1'b0;
    send(OP_BIS, 16'h00F0, 16'h0F0F, 1'b0, 4'd5);
    chk("bis_p1_sel", 16'(alu_sel), 16'(OP_XOR));
    step;
    chk("bis_p2_sel", 16'(alu_sel), 16'(OP_AND));
    step;
    chk("bis_p3_sel", 16'(alu_sel), 16'(OP_ADD));
    chk("bis_p3_a", alu_a, 16'h0FFF);
    chk("bis_p3_b", alu_b, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("bis_stall_wbv", 16'(wb_valid), 16'h1);
      chk("bis_stall_data", wb_data, 16'h0FFF);
      chk("bis_stall_ready", 16'(req_ready), 16'h0);
    end
    step;
    wb_ready = 1'b1;
    req_op = OP_ADD; req_valid = 1'b1;
    chk("bis_final_data", wb_data, 16'h0FFF);
    chk("bis_final_dst", 16'(wb_dst), 16'h5);
    step;
    req_valid = 1'b0;
    chk("bis_no_accept_in_wb", 16'(busy), 16'h0);
    chk("bis_sr", 16'(sr), 16'h6);

    // CMP equal operands: no write-back
    load_sr(4'b1000);
    send(OP_CMP, 16'h0005, 16'h0005, 1'b0, 4'd6);
    chk("cmp_p1_sel", 16'(alu_sel), 16'(OP_SUB));
    step;
    chk("cmp_ready", 16'(req_ready), 16'h1);
    chk("cmp_wbv", 16'(wb_valid), 16'h0);
    chk("cmp_sr", 16'(sr), 16'h6);

    // ADD.B then RRC.B
    load_sr(4'b0000);
    send(OP_ADD, 16'h12FF, 16'h3401, 1'b1, 4'd7);
    step;
    chk("addb_data", wb_data, 16'h0000);
    chk("addb_sr", 16'(sr), 16'h6);
    step;
    send(OP_RRC, 16'h0000, 16'h0003, 1'b1, 4'd8);
    chk("rrcb_sel", 16'(alu_sel), 16'h10);
    step;
    chk("rrcb_data", wb_data, 16'h0081);
    chk("rrcb_sr", 16'(sr), 16'hA);
    step;

    // Reset during pass 2 of SUBC
    send(OP_SUBC, 16'h0001, 16'h0010, 1'b0, 4'd9);
    chk("subc_p1_sel", 16'(alu_sel), 16'(OP_SUB));
    step;
    chk("subc_p2_a", alu_a, 16'h0000);
    chk("subc_p2_b", alu_b, 16'h000F);
    rst = 1'b1;
    #1;
    chk("abort_wbv", 16'(wb_valid), 16'h0);
    chk("abort_sr", 16'(sr), 16'h0);
    chk("abort_busy", 16'(busy), 16'h0);
    step;
    rst = 1'b0;
    step;
    chk("abort_after_wbv", 16'(wb_valid), 16'h0);

    // Back-to-back after reset release
    send(OP_SUB, 16'h0003, 16'h0005, 1'b0, 4'd1);
    step;
    chk("sub_data", wb_data, 16'h0002);
    chk("sub_sr", 16'(sr), 16'h2);
    step;
    send(OP_XOR, 16'h8000, 16'h8001, 1'b0, 4'd2);
    step;
    chk("xor_data", wb_data, 16'h0001);
    chk("xor_sr", 16'(sr), 16'h3);
    step;
    // External SR load wins over the flag update on the final pass
    req_op = OP_AND; req_a = 16'h00FF; req_b = 16'h0F00; req_byte = 1'b0; req_valid = 1'b1;
    step;
    req_valid = 1'b0;
    sr_we = 1'b1; sr_wdata = 4'b1000;
    step;
    sr_we = 1'b0;
    chk("and_data", wb_data, 16'h0000);
    chk("and_sr_we_wins", 16'(sr), 16'h8);
    step;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sits in front of the combinational 16-bit ALU and owns the processor status register (SR = {N,Z,C,V}). It accepts one operation at a time over a valid/ready handshake and maps composite ops (ADDC, SUBC, BIS) onto 2–3 ALU passes. It computes flags from its own full-precision shadow and presents the result on a write-back handshake to the register file.

Parameters:
W, 16, datapath width; byte mode uses the low 8 bits.
OPW, 5, opcode / ALU select width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  operation request valid
req_ready  out  1  sequencer idle and able to accept
req_op  in  5  opcode (package constants)
req_a  in  16  source operand
req_b  in  16  destination operand
req_byte  in  1  byte-mode (.B) operation
req_dst  in  4  destination register index
alu_sel  out  5  ALU select
alu_a  out  16  ALU operand A
alu_b  out  16  ALU operand B
alu_result  in  16  ALU combinational result
wb_valid  out  1  write-back data valid
wb_ready  in  1  register file accepts write-back
wb_dst  out  4  write-back register index
wb_data  out  16  write-back value
sr_we  in  1  external SR load (e.g. MOV to SR)
sr_wdata  in  4  external SR value {N,Z,C,V}
sr  out  4  current {N,Z,C,V}
busy  out  1  not in IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, sr=0, wb_valid=0, req_ready=1 after reset release, busy=0, temps=0. Reset mid-operation aborts the op; nothing is written back.
- States: IDLE, P1, P2, P3, WB. Accept when req_valid && req_ready; latch op, operands, byte, dst, and C_in = sr.C.
- Each pass lasts one cycle: alu_sel/alu_a/alu_b are driven from registered state; alu_result is captured into T1/T2 on the clock edge.
- Pass maps:
  - MOV, ADD, DADD (treated as ADD), SUB, XOR, AND, CLR: one pass, native select.
  - CMP: one pass on SUB, no write-back.
  - BIT: one pass on AND, no write-back.
  - BIC: one pass on AND with alu_a = ~A.
  - ADDC: P1 ADD(A,B) -> T1; P2 ADD(T1, {15'b0,C_in}).
  - SUBC: P1 SUB(B,A) -> T1; P2 SUB(T1, {15'b0,~C_in}).
  - BIS: P1 XOR -> T1; P2 AND -> T2; P3 ADD(T1,T2).
  - RRC: one pass with alu_sel=5'b10000; the result is computed locally as {C_in, B[15:1]} (byte: {C_in, B[7:1]}), and alu_result is ignored.
- Subtract convention: dst - src, i.e. B - A. CMP matches.
- Byte mode: operands are masked to [7:0] before pass 1. The result is zero-extended, msb = bit 7, and carry comes from bit 8.
- Flags are updated on the edge leaving the final pass, computed from a 17-bit shadow on the original operands:
  - Add family: C = carry-out; V = (a_msb==b_msb) && (r_msb != a_msb).
  - Sub family: C = no-borrow (B + ~A + cin ≥ 2^n); V = signed overflow of B - A.
  - AND, BIT, BIC: N = msb, Z = (r==0), C = ~Z, V = 0. BIC leaves SR unchanged.
  - XOR: as AND, except V = A_msb & B_msb.
  - RRC: C = B[0], V = 0, N and Z from the result.
  - MOV, CLR, BIS: SR unchanged.
- Write-back: ops other than CMP/BIT enter WB. wb_valid=1 with wb_data and wb_dst held stable until wb_ready; leave on that edge to IDLE.
- CMP/BIT return directly to IDLE.
- Latency, accept edge = cycle 0:
  - 1-pass: wb_valid at cycle 2.
  - 2-pass: wb_valid at cycle 3.
  - 3-pass: wb_valid at cycle 4.
  - CMP/BIT: req_ready high again at cycle 2.
- req_ready = (state==IDLE). There is no accept in WB, even if wb_ready is high that cycle.
- sr_we: loads sr on any cycle. If it coincides with an internal flag update, sr_we wins. C_in is the value latched at accept, unaffected by later sr_we.
- Undefined opcodes: treated as MOV, with no SR change.
- alu_sel/alu_a/alu_b in IDLE/WB: 0.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_MOV..OP_CLR (5'h00–5'h0C) and OP_RRC (5'h10);
  - state enum;
  - the SR bit indices N=3, Z=2, C=1, V=0.
- One natural sub-module: alu_flag_gen, a combinational 17-bit shadow plus flag equations, used by the sequencer at the final pass.
- The ALU itself is instantiated outside, beside the sequencer.

Test Plan:
- ADD A=16'h7FFF, B=16'h0001 -> wb_data=16'h8000 at cycle 2; sr=N1 Z0 C0 V1.
- ADDC with sr.C=1, A=16'hFFFF, B=16'h0000 -> passes observed P1, P2; wb_data=16'h0000 at cycle 3; sr=N0 Z1 C1 V0.
- BIS A=16'h00F0, B=16'h0F0F, wb_ready held low 3 cycles -> three ALU passes; wb_data=16'h0FFF held stable; accepted on the 4th WB cycle; SR unchanged.
- CMP A=16'h0005, B=16'h0005 -> no wb_valid; sr=N0 Z1 C1 V0; req_ready high at cycle 2.
- ADD.B A=16'h12FF, B=16'h3401 -> wb_data=16'h0000; sr=N0 Z1 C1 V0. Then RRC.B B=16'h0003 with C=1 -> wb_data=16'h0081, sr.C=1, sr.N=1.
- rst asserted during P2 of SUBC -> wb_valid never asserts; sr=0; after release, a back-to-back request is accepted.
